ps2_note_decoder: RTL and testbench
===================================

// Module: ps2_note_decoder
// PURPOSE
//  Receives PS/2 keyboard frames and decodes make/break scan codes into the 88-bit
//  note-held vector and key_pressed flag consumed by the audio codec stage.
//  Upstream neighbour of the codec: drives its sound[87:0] and key_pressed inputs.
//  The low 12 bits map to C4..B4, bit0 = C4. Bits 12..87 are held 0.
// PARAMETERS
//  FILTER_LEN   8      cycles the synced PS/2 clock must hold a level before it is accepted
//  TIMEOUT_CYC  18432  idle cycles mid-frame before abort (1 ms at 18.432 MHz)
//  NOTE_BITS    88     width of oSOUND
// PORTS
//  iCLK_18_4     in   1   system clock; the only clock
//  iRST          in   1   reset, synchronous, active-high
//  iPS2_CLK      in   1   raw PS/2 clock, asynchronous
//  iPS2_DAT      in   1   raw PS/2 data, asynchronous
//  iALL_OFF      in   1   synchronous all-notes-off request
//  oSOUND        out  88  note-held vector (codec sound input)
//  oKEY_PRESSED  out  1   registered |oSOUND (codec key_pressed input)
//  oSCAN_CODE    out  8   last valid byte; held until the next valid byte
//  oSCAN_VALID   out  1   1-cycle pulse when a good frame completes
//  oFRAME_ERR    out  1   1-cycle pulse on parity, stop or timeout error
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, brk/ext flags 0, counters 0. Reset mid-frame
//   aborts the frame with no pulse.
//  Input conditioning: 2-FF synchroniser on both lines. Filtered clock changes only
//   after FILTER_LEN consecutive equal synced samples. A falling edge of the filtered
//   clock is the sample strobe.
//  FSM (advances on strobe only):
//   IDLE   -> DATA if dat=0 (start bit); dat=1 ignored.
//   DATA   -> shift right, LSB first; 8th bit -> PARITY.
//   PARITY -> capture the parity bit -> STOP.
//   STOP   -> if stop=1 and odd parity over 9 bits: oSCAN_VALID, oSCAN_CODE<=byte.
//             Otherwise oFRAME_ERR and the byte is dropped. Both -> IDLE.
//  Timeout: counter clears on each strobe and in IDLE. In any non-IDLE state,
//   count==TIMEOUT_CYC-1 -> IDLE plus oFRAME_ERR pulse.
//  Decoder (on oSCAN_VALID):
//   0xF0 sets brk. 0xE0 sets ext.
//   Any other byte: if ext=0 and the code is mapped, sound[n] <= ~brk.
//   Then clear brk and ext; unmapped codes only clear the flags.
//  Key map: A1C W1D S1B E24 D23 F2B T2C G34 Y35 H33 U3C J3B -> n=0..11.
//  Typematic repeat of a held key leaves its bit set. Break of a key that is not
//   held has no effect.
//  iALL_OFF clears oSOUND[11:0] next cycle. It takes priority over a same-cycle make.
//  Latency: filtered stop-bit edge -> oSCAN_VALID +1 cycle -> oSOUND/oKEY_PRESSED
//   +1 cycle. oKEY_PRESSED is computed from the next-state vector, so it changes
//   together with oSOUND.
// STRUCTURE
//  Package ps2_note_pkg: scan-code constants (F0, E0, 12 key codes), note index
//   constants, FSM state encoding.
//  Sub-module ps2_rx_frame: synchroniser, filter, bit FSM and timeout.
//   Outputs: byte, valid pulse, error pulse.
//  Top level: flag logic, key map and note register.
// TESTING
//  1 Frame 0x1C, good parity -> oSCAN_VALID=1 for 1 cycle, oSCAN_CODE=0x1C;
//    next cycle oSOUND=88'h1, oKEY_PRESSED=1.
//  2 Frames F0,1C after test 1 -> oSOUND=0, oKEY_PRESSED=0; two VALID pulses.
//  3 Frame 0x24 with bad parity -> oFRAME_ERR pulse, no VALID, oSOUND unchanged.
//    Repeat with stop bit 0 -> same result.
//  4 Start bit plus 4 data bits, then clock held high 18432 cycles -> oFRAME_ERR
//    pulse; the next good 0x1D frame decodes and sets bit 1.
//  5 E0,1C -> bit 0 unchanged. Press A, W, J, then assert iALL_OFF in the same
//    cycle as the VALID pulse of a 0x23 make -> oSOUND=0.
//  6 1-cycle glitches on iPS2_CLK shorter than FILTER_LEN -> no strobe. Assert
//    iRST during DATA -> outputs 0; the next clean frame decodes normally.

Source files
------------

// File: rtl/ps2_note_pkg.sv
// Shared constants for the PS/2 note decoder: scan codes, note indices,
// receiver state encoding and the scan-code-to-note lookup.
package ps2_note_pkg;

    localparam int FILTER_LEN_DEF  = 8;
    localparam int TIMEOUT_CYC_DEF = 18432;
    localparam int NOTE_BITS_DEF   = 88;
    localparam int NUM_KEYS        = 12;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [7:0] SC_KEY_A = 8'h1C;
    localparam logic [7:0] SC_KEY_W = 8'h1D;
    localparam logic [7:0] SC_KEY_S = 8'h1B;
    localparam logic [7:0] SC_KEY_E = 8'h24;
    localparam logic [7:0] SC_KEY_D = 8'h23;
    localparam logic [7:0] SC_KEY_F = 8'h2B;
    localparam logic [7:0] SC_KEY_T = 8'h2C;
    localparam logic [7:0] SC_KEY_G = 8'h34;
    localparam logic [7:0] SC_KEY_Y = 8'h35;
    localparam logic [7:0] SC_KEY_H = 8'h33;
    localparam logic [7:0] SC_KEY_U = 8'h3C;
    localparam logic [7:0] SC_KEY_J = 8'h3B;

    localparam logic [3:0] NOTE_C4  = 4'd0;
    localparam logic [3:0] NOTE_CS4 = 4'd1;
    localparam logic [3:0] NOTE_D4  = 4'd2;
    localparam logic [3:0] NOTE_DS4 = 4'd3;
    localparam logic [3:0] NOTE_E4  = 4'd4;
    localparam logic [3:0] NOTE_F4  = 4'd5;
    localparam logic [3:0] NOTE_FS4 = 4'd6;
    localparam logic [3:0] NOTE_G4  = 4'd7;
    localparam logic [3:0] NOTE_GS4 = 4'd8;
    localparam logic [3:0] NOTE_A4  = 4'd9;
    localparam logic [3:0] NOTE_AS4 = 4'd10;
    localparam logic [3:0] NOTE_B4  = 4'd11;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } key_map_t;

    function automatic key_map_t map_key(input logic [7:0] code);
        key_map_t m;
        m.hit = 1'b1;
        m.idx = NOTE_C4;
        case (code)
            SC_KEY_A: m.idx = NOTE_C4;
            SC_KEY_W: m.idx = NOTE_CS4;
            SC_KEY_S: m.idx = NOTE_D4;
            SC_KEY_E: m.idx = NOTE_DS4;
            SC_KEY_D: m.idx = NOTE_E4;
            SC_KEY_F: m.idx = NOTE_F4;
            SC_KEY_T: m.idx = NOTE_FS4;
            SC_KEY_G: m.idx = NOTE_G4;
            SC_KEY_Y: m.idx = NOTE_GS4;
            SC_KEY_H: m.idx = NOTE_A4;
            SC_KEY_U: m.idx = NOTE_AS4;
            SC_KEY_J: m.idx = NOTE_B4;
            default:  m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises and deglitches the raw lines, then
// assembles start/8 data/odd parity/stop frames with an idle timeout.
module ps2_rx_frame
    import ps2_note_pkg::*;
#(
    parameter int FILTER_LEN  = FILTER_LEN_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       err_o
);

    localparam int FW   = $clog2(FILTER_LEN + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic            clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic            clk_filt_q, clk_filt_d;
    logic [FW-1:0]   filt_cnt_q, filt_cnt_d;
    rx_state_e       state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]      byte_q, byte_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            strobe;

    // NOTE: every register, including the synchroniser stages, uses
    // non-blocking assignment so each stage samples the previous-cycle value.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            clk_filt_q <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= RX_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_meta_q <= ps2_clk_i;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2_dat_i;
            dat_sync_q <= dat_meta_q;
            clk_filt_q <= clk_filt_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            byte_q     <= byte_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    // NOTE: all combinational outputs take a default first so no path
    // through the block leaves a signal unassigned (no latches).
    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = filt_cnt_q;
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        to_cnt_d   = to_cnt_q;
        byte_d     = byte_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        // Accept a new clock level only after FILTER_LEN consecutive disagreeing samples.
        if (clk_sync_q == clk_filt_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            clk_filt_d = clk_sync_q;
            filt_cnt_d = '0;
        end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
        end
        strobe = clk_filt_q & ~clk_filt_d;

        if (state_q == RX_IDLE || strobe) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (strobe) begin
            case (state_q)
                RX_IDLE: begin
                    if (!dat_sync_q) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = '0;
                    end
                end
                RX_DATA: begin
                    shift_d = {dat_sync_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                RX_PARITY: begin
                    par_d   = dat_sync_q;
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    if (dat_sync_q && (^{par_q, shift_q})) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end else if (state_q != RX_IDLE && to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            state_d  = RX_IDLE;
            to_cnt_d = '0;
            err_d    = 1'b1;
        end
    end

    assign byte_o  = byte_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: rtl/ps2_note_decoder.sv
// Top level: turns received scan codes into the held-note vector for the
// audio codec, tracking break (F0) and extended (E0) prefixes.
module ps2_note_decoder
    import ps2_note_pkg::*;
#(
    parameter int FILTER_LEN  = FILTER_LEN_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int NOTE_BITS   = NOTE_BITS_DEF
) (
    input  logic                 iCLK_18_4,
    input  logic                 iRST,
    input  logic                 iPS2_CLK,
    input  logic                 iPS2_DAT,
    input  logic                 iALL_OFF,
    output logic [NOTE_BITS-1:0] oSOUND,
    output logic                 oKEY_PRESSED,
    output logic [7:0]           oSCAN_CODE,
    output logic                 oSCAN_VALID,
    output logic                 oFRAME_ERR
);

    logic [7:0]          rx_byte;
    logic                rx_valid;
    logic                rx_err;
    logic                brk_q, brk_d;
    logic                ext_q, ext_d;
    logic [NUM_KEYS-1:0] sound_q, sound_d;
    logic                key_q, key_d;
    key_map_t            km;

    ps2_rx_frame #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk       (iCLK_18_4),
        .rst       (iRST),
        .ps2_clk_i (iPS2_CLK),
        .ps2_dat_i (iPS2_DAT),
        .byte_o    (rx_byte),
        .valid_o   (rx_valid),
        .err_o     (rx_err)
    );

    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            sound_q <= '0;
            key_q   <= 1'b0;
        end else begin
            brk_q   <= brk_d;
            ext_q   <= ext_d;
            sound_q <= sound_d;
            key_q   <= key_d;
        end
    end

    always_comb begin
        brk_d   = brk_q;
        ext_d   = ext_q;
        sound_d = sound_q;
        km      = map_key(rx_byte);

        if (rx_valid) begin
            if (rx_byte == SC_BREAK) begin
                brk_d = 1'b1;
            end else if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else begin
                // Extended codes never touch notes; they only consume the prefixes.
                if (!ext_q && km.hit) begin
                    sound_d[km.idx] = ~brk_q;
                end
                brk_d = 1'b0;
                ext_d = 1'b0;
            end
        end

        if (iALL_OFF) begin
            sound_d = '0;
        end
        key_d = |sound_d;
    end

    assign oSOUND       = {{(NOTE_BITS - NUM_KEYS){1'b0}}, sound_q};
    assign oKEY_PRESSED = key_q;
    assign oSCAN_CODE   = rx_byte;
    assign oSCAN_VALID  = rx_valid;
    assign oFRAME_ERR   = rx_err;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Directed bench for ps2_note_decoder: stimulus pushes expected pulses into a
// scoreboard; a monitor pops and compares whenever the DUT pulses.
module tb_ps2_note_decoder;

    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        iRST = 1'b1;
    logic        iPS2_CLK = 1'b1;
    logic        iPS2_DAT = 1'b1;
    logic        iALL_OFF = 1'b0;
    logic [87:0] oSOUND;
    logic        oKEY_PRESSED;
    logic [7:0]  oSCAN_CODE;
    logic        oSCAN_VALID;
    logic        oFRAME_ERR;

    typedef struct {
        bit         err;
        logic [7:0] code;
        logic [11:0] snd;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   armed_hit;

    always #5 clk = ~clk;

    ps2_note_decoder dut (
        .iCLK_18_4    (clk),
        .iRST         (iRST),
        .iPS2_CLK     (iPS2_CLK),
        .iPS2_DAT     (iPS2_DAT),
        .iALL_OFF     (iALL_OFF),
        .oSOUND       (oSOUND),
        .oKEY_PRESSED (oKEY_PRESSED),
        .oSCAN_CODE   (oSCAN_CODE),
        .oSCAN_VALID  (oSCAN_VALID),
        .oFRAME_ERR   (oFRAME_ERR)
    );

    task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ok(input logic [7:0] code, input logic [11:0] snd);
        exp_t e;
        e.err = 1'b0; e.code = code; e.snd = snd;
        sb.push_back(e);
    endtask

    task automatic expect_err(input logic [11:0] snd);
        exp_t e;
        e.err = 1'b1; e.code = 8'h00; e.snd = snd;
        sb.push_back(e);
    endtask

    task automatic ps2_bit(input logic b, input bit arm);
        iPS2_DAT = b;
        repeat (HALF / 2) @(negedge clk);
        iPS2_CLK = 1'b0;
        for (int i = 0; i < HALF; i++) begin
            @(negedge clk);
            if (arm && oSCAN_VALID) begin
                iALL_OFF = 1'b1;
                @(negedge clk);
                iALL_OFF = 1'b0;
                armed_hit = 1'b1;
                arm = 1'b0;
            end
        end
        iPS2_CLK = 1'b1;
        repeat (HALF / 2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit arm);
        logic par;
        par = ~(^b) ^ bad_par;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit(par, 1'b0);
        ps2_bit(~bad_stop, arm);
        iPS2_DAT = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_partial(input int nbits);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(i[0], 1'b0);
    endtask

    // Monitor: every VALID or ERR pulse consumes one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!iRST && (oSCAN_VALID || oFRAME_ERR)) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: got valid=%b err=%b code=%h expected none",
                             oSCAN_VALID, oFRAME_ERR, oSCAN_CODE);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind", {86'd0, oFRAME_ERR, oSCAN_VALID}, e.err ? 88'd2 : 88'd1);
                    if (!e.err) check("scan_code", {80'd0, oSCAN_CODE}, {80'd0, e.code});
                    @(negedge clk);
                    check("sound", oSOUND, {76'd0, e.snd});
                    check("key_pressed", {87'd0, oKEY_PRESSED}, {87'd0, |e.snd});
                    check("pulse_width", {87'd0, oSCAN_VALID | oFRAME_ERR}, 88'd0);
                end
            end
        end
    end

    initial begin
        repeat (4) @(negedge clk);
        check("rst_sound", oSOUND, 88'd0);
        check("rst_key", {87'd0, oKEY_PRESSED}, 88'd0);
        check("rst_code", {80'd0, oSCAN_CODE}, 88'd0);
        check("rst_pulses", {86'd0, oSCAN_VALID, oFRAME_ERR}, 88'd0);
        iRST = 1'b0;
        repeat (HALF) @(negedge clk);

        // Make and break of A
        expect_ok(8'h1C, 12'h001); send_frame(8'h1C, 0, 0, 0);
        expect_ok(8'hF0, 12'h001); send_frame(8'hF0, 0, 0, 0);
        expect_ok(8'h1C, 12'h000); send_frame(8'h1C, 0, 0, 0);

        // Parity and stop errors
        expect_err(12'h000); send_frame(8'h24, 1, 0, 0);
        expect_err(12'h000); send_frame(8'h24, 0, 1, 0);

        // Mid-frame timeout, then recovery
        expect_err(12'h000);
        send_partial(4);
        repeat (18432 + 300) @(negedge clk);
        expect_ok(8'h1D, 12'h002); send_frame(8'h1D, 0, 0, 0);

        // Extended code ignored, chords, typematic, stray break, unmapped
        expect_ok(8'hE0, 12'h002); send_frame(8'hE0, 0, 0, 0);
        expect_ok(8'h1C, 12'h002); send_frame(8'h1C, 0, 0, 0);
        expect_ok(8'h1C, 12'h003); send_frame(8'h1C, 0, 0, 0);
        expect_ok(8'h1D, 12'h003); send_frame(8'h1D, 0, 0, 0);
        expect_ok(8'h3B, 12'h803); send_frame(8'h3B, 0, 0, 0);
        expect_ok(8'hF0, 12'h803); send_frame(8'hF0, 0, 0, 0);
        expect_ok(8'h2B, 12'h803); send_frame(8'h2B, 0, 0, 0);
        expect_ok(8'h15, 12'h803); send_frame(8'h15, 0, 0, 0);

        // All-off coincident with a D make
        armed_hit = 1'b0;
        expect_ok(8'h23, 12'h000); send_frame(8'h23, 0, 0, 1);
        check("all_off_applied", {87'd0, armed_hit}, 88'd1);

        // Glitches shorter than the filter with data low must not start a frame
        iPS2_DAT = 1'b0;
        for (int g = 1; g <= 6; g++) begin
            iPS2_CLK = 1'b0;
            repeat (g) @(negedge clk);
            iPS2_CLK = 1'b1;
            repeat (12) @(negedge clk);
        end
        iPS2_DAT = 1'b1;
        repeat (HALF) @(negedge clk);
        expect_ok(8'h24, 12'h008); send_frame(8'h24, 0, 0, 0);

        // Reset during DATA aborts silently
        send_partial(3);
        iRST = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_sound", oSOUND, 88'd0);
        check("midrst_key", {87'd0, oKEY_PRESSED}, 88'd0);
        check("midrst_code", {80'd0, oSCAN_CODE}, 88'd0);
        iRST = 1'b0;
        iPS2_DAT = 1'b1;
        repeat (HALF) @(negedge clk);
        expect_ok(8'h34, 12'h080); send_frame(8'h34, 0, 0, 0);

        repeat (200) @(negedge clk);
        check("scoreboard_drained", 88'(sb.size()), 88'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
